// File: rtl/router_fsm.sv
// Control FSM of the 1x3 router: decodes packet headers, gates writes into the
// addressed output FIFO, stalls the source, and sequences the parity check.
module router_fsm (
    input  logic                router_clock,
    input  logic                resetn,
    input  logic                pkt_valid,
    input  logic [1:0]          data_in,
    input  logic                fifo_full,
    input  logic                fifo_empty_0,
    input  logic                fifo_empty_1,
    input  logic                fifo_empty_2,
    input  logic                soft_reset_0,
    input  logic                soft_reset_1,
    input  logic                soft_reset_2,
    input  logic                parity_done,
    input  logic                low_pkt_valid,
    output logic                busy,
    output logic                detect_add,
    output logic                lfd_state,
    output logic                ld_state,
    output logic                laf_state,
    output logic                full_state,
    output logic                write_enb_reg,
    output logic                rst_int_reg,
    output logic [1:0]          fifo_addr
);

    localparam int unsigned ADDR_W = 2;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                addr_accept;
    logic [ADDR_W-1:0]   empty_idx;
    logic                empty_sel;
    logic                sreset_sel;

    // State register and destination latch; reset is synchronous.
    always_ff @(posedge router_clock) begin
        if (!resetn) begin
            state     <= DECODE_ADDRESS;
            fifo_addr <= '0;
        end else begin
            state <= state_next;
            if (addr_accept) begin
                fifo_addr <= data_in;
            end
        end
    end

    // Next-state logic and Moore output decodes.
    always_comb begin
        state_next    = state;
        addr_accept   = 1'b0;
        empty_idx     = fifo_addr;
        empty_sel     = 1'b0;
        sreset_sel    = 1'b0;
        busy          = 1'b0;
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        write_enb_reg = 1'b0;
        rst_int_reg   = 1'b0;

        // While decoding, the incoming address picks which empty flag matters.
        if (state == DECODE_ADDRESS) begin
            empty_idx = data_in;
        end

        case (empty_idx)
            2'd0:    empty_sel = fifo_empty_0;
            2'd1:    empty_sel = fifo_empty_1;
            2'd2:    empty_sel = fifo_empty_2;
            default: empty_sel = 1'b0;
        endcase

        case (fifo_addr)
            2'd0:    sreset_sel = soft_reset_0;
            2'd1:    sreset_sel = soft_reset_1;
            2'd2:    sreset_sel = soft_reset_2;
            default: sreset_sel = 1'b0;
        endcase

        addr_accept = (state == DECODE_ADDRESS) && pkt_valid && (data_in != 2'b11);

        case (state)
            DECODE_ADDRESS: begin
                detect_add = 1'b1;
                if (addr_accept) begin
                    state_next = empty_sel ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                busy = 1'b1;
                if (empty_sel) begin
                    state_next = LOAD_FIRST_DATA;
                end
            end
            LOAD_FIRST_DATA: begin
                busy       = 1'b1;
                lfd_state  = 1'b1;
                state_next = LOAD_DATA;
            end
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
                if (fifo_full) begin
                    state_next = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    state_next = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                busy       = 1'b1;
                full_state = 1'b1;
                if (!fifo_full) begin
                    state_next = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                busy          = 1'b1;
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
                if (parity_done) begin
                    state_next = DECODE_ADDRESS;
                end else if (low_pkt_valid) begin
                    state_next = LOAD_PARITY;
                end else begin
                    state_next = LOAD_DATA;
                end
            end
            LOAD_PARITY: begin
                busy          = 1'b1;
                write_enb_reg = 1'b1;
                state_next    = CHECK_PARITY_ERROR;
            end
            CHECK_PARITY_ERROR: begin
                busy        = 1'b1;
                rst_int_reg = 1'b1;
                state_next  = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: state_next = DECODE_ADDRESS;
        endcase

        // A soft reset on the selected port aborts any in-flight packet.
        if ((state != DECODE_ADDRESS) && sreset_sel) begin
            state_next = DECODE_ADDRESS;
        end
    end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: per-scenario tasks compare the packed output
// vector and fifo_addr against hand-derived per-state values.
module tb_router_fsm;

    logic       router_clock;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       busy, detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg;
    logic [1:0] fifo_addr;

    // {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}
    localparam logic [7:0] O_DA  = 8'h80;
    localparam logic [7:0] O_LFD = 8'h41;
    localparam logic [7:0] O_LD  = 8'h22;
    localparam logic [7:0] O_LAF = 8'h13;
    localparam logic [7:0] O_FFS = 8'h09;
    localparam logic [7:0] O_CPE = 8'h05;
    localparam logic [7:0] O_LP  = 8'h03;
    localparam logic [7:0] O_WTE = 8'h01;

    logic [7:0] outs;
    assign outs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                   rst_int_reg, write_enb_reg, busy};

    int errors = 0;
    int checks = 0;

    router_fsm dut (
        .router_clock (router_clock),
        .resetn       (resetn),
        .pkt_valid    (pkt_valid),
        .data_in      (data_in),
        .fifo_full    (fifo_full),
        .fifo_empty_0 (fifo_empty_0),
        .fifo_empty_1 (fifo_empty_1),
        .fifo_empty_2 (fifo_empty_2),
        .soft_reset_0 (soft_reset_0),
        .soft_reset_1 (soft_reset_1),
        .soft_reset_2 (soft_reset_2),
        .parity_done  (parity_done),
        .low_pkt_valid(low_pkt_valid),
        .busy         (busy),
        .detect_add   (detect_add),
        .lfd_state    (lfd_state),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .full_state   (full_state),
        .write_enb_reg(write_enb_reg),
        .rst_int_reg  (rst_int_reg),
        .fifo_addr    (fifo_addr)
    );

    initial router_clock = 1'b0;
    always #5 router_clock = ~router_clock;

    task automatic step;
        @(posedge router_clock);
        #1;
    endtask

    // Drive a header for addr a with its FIFO empty and advance into LOAD_DATA.
    task automatic start_packet(input logic [1:0] a);
        pkt_valid = 1'b1;
        data_in   = a;
        case (a)
            2'd0:    fifo_empty_0 = 1'b1;
            2'd1:    fifo_empty_1 = 1'b1;
            default: fifo_empty_2 = 1'b1;
        endcase
        step();
        data_in = 2'b00;
        step();
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        step();
        checks++;
        if (outs !== O_DA) begin
            errors++;
            $display("FAIL reset_outs got=%h exp=%h", outs, O_DA);
        end
        checks++;
        if (fifo_addr !== 2'd0) begin
            errors++;
            $display("FAIL reset_addr got=%0d exp=0", fifo_addr);
        end
        resetn = 1'b1;
        step();
        checks++;
        if (outs !== O_DA) begin
            errors++;
            $display("FAIL idle_outs got=%h exp=%h", outs, O_DA);
        end
        // Address 3 is dropped no matter how long it is presented.
        pkt_valid    = 1'b1;
        data_in      = 2'b11;
        fifo_empty_0 = 1'b1;
        fifo_empty_1 = 1'b1;
        fifo_empty_2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (outs !== O_DA || fifo_addr !== 2'd0) begin
                errors++;
                $display("FAIL addr3_drop[%0d] got=%h/%0d exp=%h/0", i, outs, fifo_addr, O_DA);
            end
        end
        pkt_valid = 1'b0;
    endtask

    task automatic test_packet;
        logic [7:0] exp_seq [7];
        int wen_cnt;
        int rst_cnt;
        exp_seq = '{O_LFD, O_LD, O_LD, O_LD, O_LP, O_CPE, O_DA};
        wen_cnt = 0;
        rst_cnt = 0;
        pkt_valid = 1'b1;
        data_in   = 2'b01;
        for (int i = 0; i < 7; i++) begin
            if (i == 4) pkt_valid = 1'b0;
            step();
            if (i == 0) data_in = 2'b10;
            wen_cnt += int'(write_enb_reg);
            rst_cnt += int'(rst_int_reg);
            checks++;
            if (outs !== exp_seq[i]) begin
                errors++;
                $display("FAIL packet_seq[%0d] got=%h exp=%h", i, outs, exp_seq[i]);
            end
        end
        checks++;
        if (fifo_addr !== 2'd1) begin
            errors++;
            $display("FAIL packet_addr got=%0d exp=1", fifo_addr);
        end
        checks++;
        if (wen_cnt != 4) begin
            errors++;
            $display("FAIL packet_wen_cycles got=%0d exp=4", wen_cnt);
        end
        checks++;
        if (rst_cnt != 1) begin
            errors++;
            $display("FAIL packet_rst_int_cycles got=%0d exp=1", rst_cnt);
        end
    endtask

    task automatic test_wait_empty;
        fifo_empty_2 = 1'b0;
        pkt_valid    = 1'b1;
        data_in      = 2'b10;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) data_in = 2'b01;
            checks++;
            if (outs !== O_WTE) begin
                errors++;
                $display("FAIL wait_empty[%0d] got=%h exp=%h", i, outs, O_WTE);
            end
        end
        checks++;
        if (fifo_addr !== 2'd2) begin
            errors++;
            $display("FAIL wait_addr got=%0d exp=2", fifo_addr);
        end
        fifo_empty_2 = 1'b1;
        step();
        checks++;
        if (outs !== O_LFD) begin
            errors++;
            $display("FAIL wait_release got=%h exp=%h", outs, O_LFD);
        end
        step();
        pkt_valid = 1'b0;
        step();
        step();
        step();
        checks++;
        if (outs !== O_DA) begin
            errors++;
            $display("FAIL wait_drain got=%h exp=%h", outs, O_DA);
        end
    endtask

    task automatic test_full;
        start_packet(2'd0);
        checks++;
        if (outs !== O_LD) begin
            errors++;
            $display("FAIL full_enter_ld got=%h exp=%h", outs, O_LD);
        end
        // Stall, release, resume payload.
        fifo_full = 1'b1;
        step();
        checks++;
        if (outs !== O_FFS) begin
            errors++;
            $display("FAIL full_ffs got=%h exp=%h", outs, O_FFS);
        end
        step();
        checks++;
        if (outs !== O_FFS) begin
            errors++;
            $display("FAIL full_ffs_hold got=%h exp=%h", outs, O_FFS);
        end
        fifo_full = 1'b0;
        step();
        checks++;
        if (outs !== O_LAF) begin
            errors++;
            $display("FAIL full_laf1 got=%h exp=%h", outs, O_LAF);
        end
        step();
        checks++;
        if (outs !== O_LD) begin
            errors++;
            $display("FAIL full_laf_to_ld got=%h exp=%h", outs, O_LD);
        end
        // Stall with pkt_valid gone low during the stall.
        fifo_full = 1'b1;
        step();
        fifo_full = 1'b0;
        step();
        checks++;
        if (outs !== O_LAF) begin
            errors++;
            $display("FAIL full_laf2 got=%h exp=%h", outs, O_LAF);
        end
        low_pkt_valid = 1'b1;
        pkt_valid     = 1'b0;
        step();
        low_pkt_valid = 1'b0;
        checks++;
        if (outs !== O_LP) begin
            errors++;
            $display("FAIL full_laf_to_lp got=%h exp=%h", outs, O_LP);
        end
        // Full again during parity check re-enters the stall.
        fifo_full = 1'b1;
        step();
        step();
        checks++;
        if (outs !== O_FFS) begin
            errors++;
            $display("FAIL cpe_to_ffs got=%h exp=%h", outs, O_FFS);
        end
        fifo_full   = 1'b0;
        step();
        parity_done = 1'b1;
        step();
        parity_done = 1'b0;
        checks++;
        if (outs !== O_DA) begin
            errors++;
            $display("FAIL full_laf_to_da got=%h exp=%h", outs, O_DA);
        end
        // Fresh packet: parity_done after a stall returns straight to decode.
        start_packet(2'd1);
        fifo_full = 1'b1;
        step();
        fifo_full = 1'b0;
        step();
        parity_done = 1'b1;
        pkt_valid   = 1'b0;
        step();
        parity_done = 1'b0;
        checks++;
        if (outs !== O_DA || fifo_addr !== 2'd1) begin
            errors++;
            $display("FAIL full_parity_done got=%h/%0d exp=%h/1", outs, fifo_addr, O_DA);
        end
    endtask

    task automatic test_soft_reset;
        start_packet(2'd0);
        soft_reset_1 = 1'b1;
        step();
        soft_reset_1 = 1'b0;
        checks++;
        if (outs !== O_LD) begin
            errors++;
            $display("FAIL sreset_other got=%h exp=%h", outs, O_LD);
        end
        soft_reset_0 = 1'b1;
        step();
        soft_reset_0 = 1'b0;
        pkt_valid    = 1'b0;
        checks++;
        if (outs !== O_DA) begin
            errors++;
            $display("FAIL sreset_sel got=%h exp=%h", outs, O_DA);
        end
        step();
        checks++;
        if (outs !== O_DA) begin
            errors++;
            $display("FAIL sreset_idle got=%h exp=%h", outs, O_DA);
        end
    endtask

    task automatic test_reset_mid;
        start_packet(2'd2);
        fifo_full = 1'b1;
        step();
        checks++;
        if (outs !== O_FFS) begin
            errors++;
            $display("FAIL mid_ffs got=%h exp=%h", outs, O_FFS);
        end
        resetn    = 1'b0;
        pkt_valid = 1'b0;
        step();
        checks++;
        if (outs !== O_DA || fifo_addr !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got=%h/%0d/%b exp=%h/0/0", outs, fifo_addr, busy, O_DA);
        end
        resetn    = 1'b1;
        fifo_full = 1'b0;
        step();
    endtask

    task automatic test_back_to_back;
        // Header presented in the same cycle the previous packet returns to decode.
        start_packet(2'd2);
        pkt_valid = 1'b0;
        step();
        step();
        pkt_valid = 1'b1;
        data_in   = 2'b01;
        step();
        checks++;
        if (outs !== O_DA) begin
            errors++;
            $display("FAIL b2b_da got=%h exp=%h", outs, O_DA);
        end
        step();
        pkt_valid = 1'b0;
        checks++;
        if (outs !== O_LFD || fifo_addr !== 2'd1) begin
            errors++;
            $display("FAIL b2b_lfd got=%h/%0d exp=%h/1", outs, fifo_addr, O_LFD);
        end
        step();
        step();
        step();
        step();
    endtask

    initial begin
        resetn        = 1'b0;
        pkt_valid     = 1'b0;
        data_in       = 2'b00;
        fifo_full     = 1'b0;
        fifo_empty_0  = 1'b0;
        fifo_empty_1  = 1'b0;
        fifo_empty_2  = 1'b0;
        soft_reset_0  = 1'b0;
        soft_reset_1  = 1'b0;
        soft_reset_2  = 1'b0;
        parity_done   = 1'b0;
        low_pkt_valid = 1'b0;
        #2;
        test_reset();
        test_packet();
        test_wait_empty();
        test_full();
        test_soft_reset();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
